// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - time-set and alarm controller for digital_clock
// Edit FSM for time/alarm fields, one-cycle load strobe, and a bounded alarm ring.
module clock_set_ctrl #(
  parameter int RING_CYCLES = 1000
) (
  input  logic       master_clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       alarm_en,
  input  logic [1:0] cur_hours_p1,
  input  logic [3:0] cur_hours_p2,
  input  logic [2:0] cur_minutes_p1,
  input  logic [3:0] cur_minutes_p2,
  input  logic [2:0] cur_seconds_p1,
  input  logic [3:0] cur_seconds_p2,
  output logic [2:0] state,
  output logic       load,
  output logic [1:0] load_hours_p1,
  output logic [3:0] load_hours_p2,
  output logic [2:0] load_minutes_p1,
  output logic [3:0] load_minutes_p2,
  output logic       alarm_on
);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    SET_HR  = 3'd1,
    SET_MIN = 3'd2,
    COMMIT  = 3'd3,
    ALM_HR  = 3'd4,
    ALM_MIN = 3'd5
  } state_t;

  localparam int CW = (RING_CYCLES < 2) ? 1 : $clog2(RING_CYCLES + 1);

  state_t        state_q, state_n;
  logic [5:0]    hr_q, hr_n, ahr_q, ahr_n;
  logic [6:0]    min_q, min_n, amin_q, amin_n;
  logic          load_q, load_n;
  logic          alarm_q, alarm_n;
  logic [CW-1:0] ring_q, ring_n;
  logic          match, match_d;
  logic          mode_p, inc_p;
  logic [5:0]    cur_hr;
  logic [6:0]    cur_min;

  // Fields are packed {tens, ones} so BCD literals like 6'h23 read naturally.
  function automatic logic [5:0] hr_inc(input logic [5:0] h);
    if (h == 6'h23)          return 6'h00;
    else if (h[3:0] == 4'd9) return {h[5:4] + 2'd1, 4'd0};
    else                     return {h[5:4], h[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] min_inc(input logic [6:0] m);
    if (m == 7'h59)          return 7'h00;
    else if (m[3:0] == 4'd9) return {m[6:4] + 3'd1, 4'd0};
    else                     return {m[6:4], m[3:0] + 4'd1};
  endfunction

  assign cur_hr  = {cur_hours_p1, cur_hours_p2};
  assign cur_min = {cur_minutes_p1, cur_minutes_p2};

  // A press during ringing only silences the alarm; mode beats inc.
  assign mode_p = btn_mode & ~alarm_q;
  assign inc_p  = btn_inc & ~btn_mode & ~alarm_q;

  assign match = (state_q == RUN) && alarm_en && (cur_hr == ahr_q) && (cur_min == amin_q) &&
                 (cur_seconds_p1 == 3'd0) && (cur_seconds_p2 == 4'd0);

  always_comb begin
    state_n = state_q;
    hr_n    = hr_q;
    min_n   = min_q;
    ahr_n   = ahr_q;
    amin_n  = amin_q;
    case (state_q)
      RUN: if (mode_p) begin
        state_n = SET_HR;
        hr_n    = cur_hr;
        min_n   = cur_min;
      end
      SET_HR:  if (mode_p) state_n = SET_MIN; else if (inc_p) hr_n = hr_inc(hr_q);
      SET_MIN: if (mode_p) state_n = COMMIT;  else if (inc_p) min_n = min_inc(min_q);
      COMMIT:  state_n = ALM_HR;
      ALM_HR:  if (mode_p) state_n = ALM_MIN; else if (inc_p) ahr_n = hr_inc(ahr_q);
      ALM_MIN: if (mode_p) state_n = RUN;     else if (inc_p) amin_n = min_inc(amin_q);
      default: state_n = RUN;
    endcase
    load_n = (state_n == COMMIT);

    alarm_n = alarm_q;
    ring_n  = ring_q;
    if (alarm_q && (btn_mode || btn_inc || !alarm_en)) begin
      alarm_n = 1'b0;
      ring_n  = '0;
    end else if (match && !match_d) begin
      alarm_n = 1'b1;
      ring_n  = CW'(RING_CYCLES);
    end else if (alarm_q) begin
      if (ring_q <= CW'(1)) begin
        alarm_n = 1'b0;
        ring_n  = '0;
      end else begin
        ring_n = ring_q - CW'(1);
      end
    end
  end

  always_ff @(posedge master_clk) begin
    if (reset) begin
      state_q <= RUN;
      hr_q    <= '0;
      min_q   <= '0;
      ahr_q   <= '0;
      amin_q  <= '0;
      load_q  <= 1'b0;
      alarm_q <= 1'b0;
      ring_q  <= '0;
      match_d <= 1'b0;
    end else begin
      state_q <= state_n;
      hr_q    <= hr_n;
      min_q   <= min_n;
      ahr_q   <= ahr_n;
      amin_q  <= amin_n;
      load_q  <= load_n;
      alarm_q <= alarm_n;
      ring_q  <= ring_n;
      match_d <= match;
    end
  end

  assign state           = state_q;
  assign load            = load_q;
  assign load_hours_p1   = hr_q[5:4];
  assign load_hours_p2   = hr_q[3:0];
  assign load_minutes_p1 = min_q[6:4];
  assign load_minutes_p2 = min_q[3:0];
  assign alarm_on        = alarm_q;

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Time-set and alarm controller for the team's digital_clock. It takes single-cycle button pulses and steps through edit modes, letting the user adjust hours and minutes. It commits the edited time to the clock through a one-cycle load strobe, which loads seconds as 00. It also holds an alarm time, compares it against the running clock outputs, and drives a bounded ring output.

Parameters:
RING_CYCLES, 1000, number of master_clk cycles alarm_on stays high per trigger (must be >= 1)

Ports:
master_clk  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
btn_mode  input  1  debounced one-cycle pulse; advances the edit mode
btn_inc  input  1  debounced one-cycle pulse; increments the field being edited
alarm_en  input  1  level; enables alarm matching
cur_hours_p1  input  2  clock hours tens (BCD)
cur_hours_p2  input  4  clock hours ones (BCD)
cur_minutes_p1  input  3  clock minutes tens
cur_minutes_p2  input  4  clock minutes ones
cur_seconds_p1  input  3  clock seconds tens
cur_seconds_p2  input  4  clock seconds ones
state  output  3  0=RUN 1=SET_HR 2=SET_MIN 3=COMMIT 4=ALM_HR 5=ALM_MIN
load  output  1  one-cycle strobe to digital_clock; load seconds as 00
load_hours_p1  output  2  time edit register, hours tens
load_hours_p2  output  4  time edit register, hours ones
load_minutes_p1  output  3  time edit register, minutes tens
load_minutes_p2  output  4  time edit register, minutes ones
alarm_on  output  1  ring indication

Behaviour:
- Reset (sync, master_clk edge with reset=1):
  - state=RUN, load=0, alarm_on=0.
  - Time edit registers=00:00, alarm registers=00:00.
  - Ring counter=0, match history=0.
- All outputs are registered.
- btn_mode transitions, taking effect on the next edge:
  - RUN->SET_HR
  - SET_HR->SET_MIN
  - SET_MIN->COMMIT
  - ALM_HR->ALM_MIN
  - ALM_MIN->RUN
- COMMIT:
  - Lasts exactly one cycle and always moves to ALM_HR; buttons in COMMIT are ignored.
  - load=1 only while state==COMMIT.
- On the RUN->SET_HR edge, the time edit registers capture the cur_hours/cur_minutes digits.
- btn_inc in SET_HR:
  - Hours +1 in BCD; ones 9 carries to tens; 23 wraps to 00.
- btn_inc in SET_MIN:
  - Minutes +1 in BCD; 59 wraps to 00; no carry into hours.
- btn_inc in ALM_HR / ALM_MIN: same rules applied to the alarm registers.
- btn_inc in RUN: no effect on time or alarm registers.
- btn_mode and btn_inc in the same cycle: mode wins, inc is discarded.
- Alarm matching:
  - match = (state==RUN) & alarm_en & (cur hours/min == alarm regs) & (cur seconds == 00).
  - A trigger is a rising edge of match: match=1 while the registered match_d=0.
  - On the edge where a trigger is sampled, alarm_on goes 1 and the counter loads RING_CYCLES.
  - alarm_on stays high exactly RING_CYCLES cycles, then drops.
  - A match held for many cycles does not retrigger.
- Ring cancel:
  - Any button pulse while alarm_on=1 clears alarm_on on the next edge.
  - That pulse is consumed: no mode change, no increment.
  - alarm_en=0 clears alarm_on on the next edge.
- Leaving RUN cannot occur while ringing, because the first button press only cancels the ring.
- Reset mid-edit (any state): returns to RUN, no load pulse, edit and alarm registers cleared.
- load_* outputs reflect the time edit registers continuously and are only meaningful when load=1.

Test Plan:
- Reset asserted 3 cycles -> state=0, load=0, load_*=00:00, alarm_on=0.
- cur=13:45:12; mode; inc x11 (13->00); mode; inc x2; mode -> state 1, hours reach 00, minutes 47; load=1 for exactly one cycle with load_*=00:47, next cycle state=4, load=0.
- Wrap/BCD checks: hours 09+1->10 (p1=1,p2=0); hours 23+1->00; minutes 59+1->00 with hours unchanged; simultaneous mode+inc in SET_HR -> state=2, hours unchanged.
- RING_CYCLES=20; alarm set 07:30 via ALM states; alarm_en=1; cur=07:30:00 held 100 cycles in RUN -> alarm_on rises 1 cycle after match, high exactly 20 cycles, no retrigger.
- While ringing, btn_inc pulse -> alarm_on=0 next cycle, state stays RUN, registers unchanged; repeat with btn_mode -> state stays RUN.
- Reset pulsed while state=SET_MIN -> state=0, no load strobe ever seen, alarm registers read back 00:00 via a subsequent alarm match at 00:00:00.
